// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the register file write port.
// Define REG_WB_QUEUE_BYPASS_EN to build the youngest-match bypass lookups; otherwise hit outputs read 0.
module reg_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      stall,
  output logic [ADDR_W-1:0]         write_w,
  output logic [DATA_W-1:0]         write_data_w,
  output logic                      ctrl_regwrite,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  input  logic [ADDR_W-1:0]         lookup1_w,
  input  logic [ADDR_W-1:0]         lookup2_w,
  output logic                      hit1,
  output logic                      hit2,
  output logic [DATA_W-1:0]         hit_data1,
  output logic [DATA_W-1:0]         hit_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  logic              push;
  logic              pop;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = !full;

  // Writes to register 0 complete the handshake but never occupy a slot.
  assign accept = in_valid && in_ready;
  assign push   = accept && (in_addr != '0);
  assign pop    = ctrl_regwrite;

  assign ctrl_regwrite = !empty && !stall;
  assign write_w       = empty ? '0 : addr_mem[rd_ptr];
  assign write_data_w  = empty ? '0 : data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

`ifdef REG_WB_QUEUE_BYPASS_EN
  // Walk oldest to youngest so the last match found is the youngest one.
  function automatic logic [DATA_W:0] find_youngest(input logic [ADDR_W-1:0] key);
    logic [DATA_W:0] r;
    logic [PTR_W-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (key != '0) && (addr_mem[idx] == key))
        r = {1'b1, data_mem[idx]};
    end
    return r;
  endfunction

  always_comb begin
    {hit1, hit_data1} = find_youngest(lookup1_w);
    {hit2, hit_data2} = find_youngest(lookup2_w);
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup1_w, lookup2_w};
  assign hit1      = 1'b0;
  assign hit2      = 1'b0;
  assign hit_data1 = '0;
  assign hit_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed cycle table, then random traffic against a queue model.
module tb_reg_wb_queue;

`ifdef REG_WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall, ctrl_regwrite, empty, full;
  logic [4:0]  in_addr, write_w, lookup1_w, lookup2_w;
  logic [31:0] in_data, write_data_w, hit_data1, hit_data2;
  logic [2:0]  count;
  logic        hit1, hit2;

  always #5 clk = ~clk;

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .stall(stall),
    .write_w(write_w), .write_data_w(write_data_w), .ctrl_regwrite(ctrl_regwrite),
    .count(count), .empty(empty), .full(full),
    .lookup1_w(lookup1_w), .lookup2_w(lookup2_w),
    .hit1(hit1), .hit2(hit2), .hit_data1(hit_data1), .hit_data2(hit_data2)
  );

  typedef struct {
    bit rst; bit valid; logic [4:0] addr; logic [31:0] data; bit stall;
    logic [4:0] l1; logic [4:0] l2;
    int e_cnt; bit e_ctrl; logic [4:0] e_ww; logic [31:0] e_wd;
    bit e_h1; logic [31:0] e_hd1; bit e_h2; logic [31:0] e_hd2;
  } vec_t;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input bit r, input bit v, input logic [4:0] a, input logic [31:0] d,
                       input bit s, input logic [4:0] l1, input logic [4:0] l2);
    rst = r; in_valid = v; in_addr = a; in_data = d; stall = s;
    lookup1_w = l1; lookup2_w = l2;
    @(negedge clk);
  endtask

  function automatic logic [32:0] model_hit(input logic [4:0] key);
    if (!BYP || key == 5'd0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == key) return {1'b1, q[i].d};
    return '0;
  endfunction

  task automatic check_model();
    logic [32:0] h1, h2;
    h1 = model_hit(lookup1_w);
    h2 = model_hit(lookup2_w);
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("m_regwrite", 32'(ctrl_regwrite), 32'(q.size() > 0 && !stall));
    chk("m_write_w", 32'(write_w), q.size() > 0 ? 32'(q[0].a) : 32'd0);
    chk("m_write_data", write_data_w, q.size() > 0 ? q[0].d : 32'd0);
    chk("m_hit1", 32'(hit1), 32'(h1[32]));
    chk("m_hit_data1", hit_data1, h1[31:0]);
    chk("m_hit2", 32'(hit2), 32'(h2[32]));
    chk("m_hit_data2", hit_data2, h2[31:0]);
  endtask

  task automatic advance();
    bit do_pop, do_acc;
    ent_t e;
    if (rst) q.delete();
    else begin
      do_pop = q.size() > 0 && !stall;
      do_acc = in_valid && q.size() < DEPTH;
      if (do_pop) void'(q.pop_front());
      if (do_acc && in_addr != 5'd0) begin
        e.a = in_addr; e.d = in_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tbl[32];

  initial begin
    tbl[0]  = '{0,1,5,32'hDEADBEEF,0,0,0, 0,0,0,0,          0,0,0,0};
    tbl[1]  = '{0,0,0,0,0,0,0,          1,1,5,32'hDEADBEEF, 0,0,0,0};
    tbl[2]  = '{0,0,0,0,0,0,0,          0,0,0,0,            0,0,0,0};
    tbl[3]  = '{0,1,0,32'h1234,0,0,0,   0,0,0,0,            0,0,0,0};
    tbl[4]  = '{0,0,0,0,0,0,0,          0,0,0,0,            0,0,0,0};
    tbl[5]  = '{0,1,1,32'hA1,1,0,0,     0,0,0,0,            0,0,0,0};
    tbl[6]  = '{0,1,2,32'hA2,1,0,0,     1,0,1,32'hA1,       0,0,0,0};
    tbl[7]  = '{0,1,3,32'hA3,1,0,0,     2,0,1,32'hA1,       0,0,0,0};
    tbl[8]  = '{0,1,4,32'hA4,1,0,0,     3,0,1,32'hA1,       0,0,0,0};
    tbl[9]  = '{0,1,9,32'hBAD,1,0,0,    4,0,1,32'hA1,       0,0,0,0};
    tbl[10] = '{0,0,0,0,0,0,0,          4,1,1,32'hA1,       0,0,0,0};
    tbl[11] = '{0,0,0,0,0,0,0,          3,1,2,32'hA2,       0,0,0,0};
    tbl[12] = '{0,0,0,0,0,0,0,          2,1,3,32'hA3,       0,0,0,0};
    tbl[13] = '{0,0,0,0,0,0,0,          1,1,4,32'hA4,       0,0,0,0};
    tbl[14] = '{0,0,0,0,0,0,0,          0,0,0,0,            0,0,0,0};
    tbl[15] = '{0,1,7,32'h11,1,7,0,     0,0,0,0,            0,0,0,0};
    tbl[16] = '{0,1,7,32'h22,1,7,0,     1,0,7,32'h11,       1,32'h11,0,0};
    tbl[17] = '{0,0,0,0,1,7,0,          2,0,7,32'h11,       1,32'h22,0,0};
    tbl[18] = '{0,0,0,0,0,7,7,          2,1,7,32'h11,       1,32'h22,1,32'h22};
    tbl[19] = '{0,0,0,0,0,7,7,          1,1,7,32'h22,       1,32'h22,1,32'h22};
    tbl[20] = '{0,0,0,0,0,7,7,          0,0,0,0,            0,0,0,0};
    tbl[21] = '{0,1,10,32'h10,1,0,0,    0,0,0,0,            0,0,0,0};
    tbl[22] = '{0,1,11,32'h11,1,0,0,    1,0,10,32'h10,      0,0,0,0};
    tbl[23] = '{0,1,12,32'h12,1,0,0,    2,0,10,32'h10,      0,0,0,0};
    tbl[24] = '{0,1,13,32'h13,1,0,0,    3,0,10,32'h10,      0,0,0,0};
    tbl[25] = '{0,1,14,32'h14,0,0,0,    4,1,10,32'h10,      0,0,0,0};
    tbl[26] = '{0,1,14,32'h14,0,0,0,    3,1,11,32'h11,      0,0,0,0};
    tbl[27] = '{0,1,15,32'h15,0,0,0,    3,1,12,32'h12,      0,0,0,0};
    tbl[28] = '{0,1,16,32'h16,0,0,0,    3,1,13,32'h13,      0,0,0,0};
    tbl[29] = '{1,1,17,32'h17,0,15,0,   3,1,14,32'h14,      1,32'h15,0,0};
    tbl[30] = '{0,0,0,0,0,15,0,         0,0,0,0,            0,0,0,0};
    tbl[31] = '{0,0,0,0,0,15,17,        0,0,0,0,            0,0,0,0};

    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0;
    lookup1_w = '0; lookup2_w = '0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();

    apply(0, 0, 0, 0, 0, 3, 4);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_regwrite", 32'(ctrl_regwrite), 32'd0);
    chk("rst_write_w", 32'(write_w), 32'd0);
    chk("rst_write_data", write_data_w, 32'd0);
    chk("rst_hits", 32'({hit1, hit2}), 32'd0);
    advance();

    for (int i = 0; i < 32; i++) begin
      apply(tbl[i].rst, tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].l1, tbl[i].l2);
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_cnt < DEPTH));
      chk($sformatf("t%0d_full", i), 32'(full), 32'(tbl[i].e_cnt == DEPTH));
      chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
      chk($sformatf("t%0d_regwrite", i), 32'(ctrl_regwrite), 32'(tbl[i].e_ctrl));
      chk($sformatf("t%0d_write_w", i), 32'(write_w), 32'(tbl[i].e_ww));
      chk($sformatf("t%0d_write_data", i), write_data_w, tbl[i].e_wd);
      chk($sformatf("t%0d_hit1", i), 32'(hit1), 32'(BYP & tbl[i].e_h1));
      chk($sformatf("t%0d_hit_data1", i), hit_data1, BYP ? tbl[i].e_hd1 : 32'd0);
      chk($sformatf("t%0d_hit2", i), 32'(hit2), 32'(BYP & tbl[i].e_h2));
      chk($sformatf("t%0d_hit_data2", i), hit_data2, BYP ? tbl[i].e_hd2 : 32'd0);
      check_model();
      advance();
    end

    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(199, 0) == 0,
            $urandom_range(9, 0) < 7,
            5'($urandom_range(7, 0)),
            $urandom,
            $urandom_range(9, 0) < 3,
            5'($urandom_range(7, 0)),
            5'($urandom_range(7, 0)));
      check_model();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
